// File: rtl/muldiv_fu.sv
// Iterative RV32M multiply/divide unit: one operation in flight, XLEN iterations,
// result held on the update bus until the writeback ring accepts it.
module muldiv_fu #(
  parameter int XLEN          = 32,
  parameter int PHYS_REG_SIZE = 256,
  parameter int ROB_SIZE      = 265,
  parameter int UOP_SIZE      = 16,
  localparam int RW = $clog2(ROB_SIZE),
  localparam int DW = $clog2(PHYS_REG_SIZE),
  localparam int UW = $clog2(UOP_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [RW-1:0]   rob_entry_in,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [UW-1:0]   uop_encoding_in,
  input  logic [DW-1:0]   dest_reg_in,
  input  logic            flush,
  output logic            ready,
  input  logic            out_ready,
  output logic            result_valid,
  output logic [RW-1:0]   result_rob,
  output logic [DW-1:0]   result_dest,
  output logic [XLEN-1:0] result_val
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   rob_q;
  logic [DW-1:0]   dest_q;
  logic [UW-1:0]   uop_q;
  logic [XLEN-1:0] opa;   // multiplicand magnitude, or divisor magnitude
  logic [XLEN-1:0] acc;   // product high half, or partial remainder
  logic [XLEN-1:0] quo;   // multiplier/product low half, or dividend/quotient
  logic            neg_q; // negate product or quotient at the end
  logic            neg_r; // negate remainder at the end

  assign ready = (state == IDLE);

  // Operand decode for the incoming uop
  logic            in_s1, in_s2, in_div, in_neg1, in_neg2;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    in_s1 = 1'b0;
    in_s2 = 1'b0;
    case (uop_encoding_in)
      UW'(1), UW'(4), UW'(6): begin
        in_s1 = 1'b1;
        in_s2 = 1'b1;
      end
      UW'(2):  in_s1 = 1'b1;
      default: ;
    endcase
    in_div  = uop_encoding_in inside {UW'(4), UW'(5), UW'(6), UW'(7)};
    in_neg1 = in_s1 & rs1[XLEN-1];
    in_neg2 = in_s2 & rs2[XLEN-1];
    mag1    = in_neg1 ? -rs1 : rs1;
    mag2    = in_neg2 ? -rs2 : rs2;
  end

  // One iteration of shift-add multiply and of restoring divide
  logic            q_div;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_rem;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;
  logic [XLEN-1:0] nxt_acc, nxt_quo;
  logic [2*XLEN-1:0] sprod;
  logic [XLEN-1:0] qv, rv, fin;

  always_comb begin
    q_div   = uop_q inside {UW'(4), UW'(5), UW'(6), UW'(7)};
    mul_sum = {1'b0, acc} + {1'b0, (quo[0] ? opa : '0)};
    div_rem = {acc, quo[XLEN-1]};
    div_ge  = div_rem >= {1'b0, opa};
    div_sub = div_rem[XLEN-1:0] - opa;
    if (q_div) begin
      nxt_acc = div_ge ? div_sub : div_rem[XLEN-1:0];
      nxt_quo = {quo[XLEN-2:0], div_ge};
    end else begin
      nxt_acc = mul_sum[XLEN:1];
      nxt_quo = {mul_sum[0], quo[XLEN-1:1]};
    end
    sprod = neg_q ? -{nxt_acc, nxt_quo} : {nxt_acc, nxt_quo};
    qv    = neg_q ? -nxt_quo : nxt_quo;
    rv    = neg_r ? -nxt_acc : nxt_acc;
    case (uop_q)
      UW'(0):                 fin = sprod[XLEN-1:0];
      UW'(1), UW'(2), UW'(3): fin = sprod[2*XLEN-1:XLEN];
      UW'(4), UW'(5):         fin = qv;
      UW'(6), UW'(7):         fin = rv;
      default:                fin = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rob_q        <= '0;
      dest_q       <= '0;
      uop_q        <= '0;
      opa          <= '0;
      acc          <= '0;
      quo          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      result_valid <= 1'b0;
      result_rob   <= '0;
      result_dest  <= '0;
      result_val   <= '0;
    end else if (flush) begin
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            rob_q  <= rob_entry_in;
            dest_q <= dest_reg_in;
            uop_q  <= uop_encoding_in;
            cnt    <= '0;
            acc    <= '0;
            state  <= BUSY;
            // Divide by zero keeps the all-ones quotient unsigned; the natural
            // remainder (|rs1| re-signed) already equals rs1.
            if (in_div) begin
              opa   <= mag2;
              quo   <= mag1;
              neg_q <= (in_neg1 ^ in_neg2) & (rs2 != '0);
            end else begin
              opa   <= mag1;
              quo   <= mag2;
              neg_q <= in_neg1 ^ in_neg2;
            end
            neg_r <= in_neg1;
          end
        end
        BUSY: begin
          acc <= nxt_acc;
          quo <= nxt_quo;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) begin
            result_val   <= fin;
            result_rob   <= rob_q;
            result_dest  <= dest_q;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_fu.sv
// Directed self-checking bench for muldiv_fu with hand-computed RV32M results.
module tb_muldiv_fu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [8:0]  rob_entry_in = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [3:0]  uop_encoding_in = '0;
  logic [7:0]  dest_reg_in = '0;
  logic        flush = 1'b0;
  logic        ready;
  logic        out_ready = 1'b0;
  logic        result_valid;
  logic [8:0]  result_rob;
  logic [7:0]  result_dest;
  logic [31:0] result_val;

  int checks = 0;
  int errors = 0;
  int tagno  = 0;

  muldiv_fu #(.XLEN(32), .PHYS_REG_SIZE(256), .ROB_SIZE(265), .UOP_SIZE(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .rob_entry_in(rob_entry_in),
    .rs1(rs1), .rs2(rs2), .uop_encoding_in(uop_encoding_in), .dest_reg_in(dest_reg_in),
    .flush(flush), .ready(ready), .out_ready(out_ready), .result_valid(result_valid),
    .result_rob(result_rob), .result_dest(result_dest), .result_val(result_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one uop for a single edge; called at #1 after a rising edge.
  task automatic issue(input logic [3:0] uop, input logic [31:0] a, input logic [31:0] b);
    tagno++;
    valid_in        = 1'b1;
    uop_encoding_in = uop;
    rs1             = a;
    rs2             = b;
    rob_entry_in    = 9'(100 + tagno);
    dest_reg_in     = 8'(3 * tagno + 1);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!result_valid && lat < 40);
    check({tag, "_latency"}, lat, 32);
  endtask

  task automatic run_op(input string tag, input logic [3:0] uop, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    out_ready = 1'b1;
    issue(uop, a, b);
    check({tag, "_busy"}, ready, 0);
    wait_result(tag);
    check(tag, result_val, exp);
    check({tag, "_rob"}, result_rob, 9'(100 + tagno));
    check({tag, "_dest"}, result_dest, 8'(3 * tagno + 1));
    @(posedge clk);
    #1;
    check({tag, "_handoff"}, result_valid, 0);
    check({tag, "_ready"}, ready, 1);
  endtask

  task automatic watch_no_result(input string tag);
    int rises;
    rises = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (result_valid) rises++;
    end
    check(tag, rises, 0);
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_valid", result_valid, 0);
    check("rst_rob", result_rob, 0);
    check("rst_dest", result_dest, 0);
    check("rst_val", result_val, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul", 4'd0, 32'd7, 32'd6, 32'd42);
    run_op("mul_neg", 4'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
    run_op("mulh", 4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    run_op("mulhu", 4'd3, 32'hFFFFFFFF, 32'd2, 32'h00000001);
    run_op("mulhsu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div", 4'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_op("rem", 4'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_op("div_negdiv", 4'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    run_op("rem_negdiv", 4'd6, 32'd7, 32'hFFFFFFFE, 32'd1);
    run_op("divu", 4'd5, 32'd100, 32'd7, 32'd14);
    run_op("remu", 4'd7, 32'd100, 32'd7, 32'd2);
    run_op("divu_zero", 4'd5, 32'd100, 32'd0, 32'hFFFFFFFF);
    run_op("remu_zero", 4'd7, 32'd100, 32'd0, 32'd100);
    run_op("div_zero", 4'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF);
    run_op("rem_zero", 4'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);
    run_op("div_ovf", 4'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf", 4'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    run_op("illegal", 4'd9, 32'd123, 32'd45, 32'd0);

    // Back-pressure: result held while out_ready=0, new uops ignored
    out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd5);
    wait_result("bp");
    check("bp_val", result_val, 32'd15);
    bad = 0;
    repeat (10) begin
      valid_in = 1'b1;
      uop_encoding_in = 4'd0;
      rs1 = 32'd100;
      rs2 = 32'd100;
      @(posedge clk);
      #1 if (result_val !== 32'd15 || ready !== 1'b0 || result_valid !== 1'b1 ||
             result_rob !== 9'(100 + tagno)) bad++;
    end
    valid_in = 1'b0;
    check("bp_hold", bad, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_handoff", result_valid, 0);
    check("bp_ready", ready, 1);
    watch_no_result("bp_ignored");

    // Flush mid-divide
    issue(4'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_ready", ready, 1);
    watch_no_result("flush_noresult");

    // Flush coincident with a dispatched uop
    valid_in = 1'b1;
    flush = 1'b1;
    uop_encoding_in = 4'd0;
    rs1 = 32'd2;
    rs2 = 32'd2;
    @(posedge clk);
    #1 begin
      valid_in = 1'b0;
      flush = 1'b0;
    end
    check("flushacc_ready", ready, 1);
    watch_no_result("flushacc_noresult");

    // Reset while holding a result
    out_ready = 1'b0;
    issue(4'd0, 32'd7, 32'd6);
    wait_result("rstdone");
    check("rstdone_val", result_val, 32'd42);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    check("rstdone_valid", result_valid, 0);
    check("rstdone_val0", result_val, 0);
    check("rstdone_rob", result_rob, 0);
    check("rstdone_dest", result_dest, 0);
    check("rstdone_ready", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
